// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and small decode helpers.
// Pixel-source blocks import this so that they agree with the controller.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  // Horizontal timing, in pixel clocks.
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 40;
  localparam int H_LEFT  = 8;
  localparam int H_VALID = 640;
  localparam int H_RIGHT = 8;
  localparam int H_FRONT = 8;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;

  // Vertical timing, in lines.
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 25;
  localparam int V_TOP    = 8;
  localparam int V_VALID  = 480;
  localparam int V_BOTTOM = 8;
  localparam int V_FRONT  = 2;
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

  // First active column and row.
  localparam int HS = H_SYNC + H_BACK + H_LEFT;
  localparam int VS = V_SYNC + V_BACK + V_TOP;

  // Inclusive window test on a 10-bit unsigned counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: a wrap counter 0..TOTAL-1 with enable, a terminal-count
// flag and the sync-pulse decode (high for the first SYNC counts).
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int SYNC  = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             sync
);

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC - 1);

  // Count on enable, wrapping to zero on the same cycle as the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  // Terminal count and sync pulse are pure decodes of the registered count.
  always_comb begin
    tc   = (cnt == LAST);
    sync = (cnt <= SYNC_LAST);
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing controller: two cascaded axis counters, sync decode, a pixel
// request window one clock ahead of the active window, and a combinational
// pass-through of pix_data during active video (black elsewhere).
module vga_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BACK   = vga_timing_pkg::H_BACK,
  parameter int H_LEFT   = vga_timing_pkg::H_LEFT,
  parameter int H_VALID  = vga_timing_pkg::H_VALID,
  parameter int H_RIGHT  = vga_timing_pkg::H_RIGHT,
  parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BACK   = vga_timing_pkg::V_BACK,
  parameter int V_TOP    = vga_timing_pkg::V_TOP,
  parameter int V_VALID  = vga_timing_pkg::V_VALID,
  parameter int V_BOTTOM = vga_timing_pkg::V_BOTTOM,
  parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
);

  // Reject inconsistent timing sets at elaboration.
  localparam int H_SUM = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_SUM = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  if (H_SUM != H_TOTAL || V_SUM != V_TOTAL || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
    $error("vga_ctrl: timing parameters inconsistent or exceed 10 bits");
  end

  // Window bounds; the request window leads the active window by one clock.
  localparam logic [9:0] HS_L    = 10'(H_SYNC + H_BACK + H_LEFT);
  localparam logic [9:0] VS_L    = 10'(V_SYNC + V_BACK + V_TOP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);
  localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK + H_LEFT - 1);
  localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 2);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_TOP + V_VALID - 1);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_tc;
  logic       v_tc;
  logic       rgb_valid;
  logic       pix_req;
  logic       row_act;

  vga_axis_cnt #(.TOTAL(H_TOTAL), .SYNC(H_SYNC)) u_h_cnt (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .en    (1'b1),
    .cnt   (cnt_h),
    .tc    (h_tc),
    .sync  (hsync)
  );

  // Vertical axis advances once per line, on the horizontal terminal count.
  vga_axis_cnt #(.TOTAL(V_TOTAL), .SYNC(V_SYNC)) u_v_cnt (
    .clk   (vga_clk),
    .rst_n (sys_rst_n),
    .en    (h_tc),
    .cnt   (cnt_v),
    .tc    (v_tc),
    .sync  (vsync)
  );

  // Window decode, pixel coordinates and black-outside-active pixel mux.
  always_comb begin
    row_act   = in_window(cnt_v, VS_L, V_ACT_HI);
    rgb_valid = row_act && in_window(cnt_h, HS_L, H_ACT_HI);
    pix_req   = row_act && in_window(cnt_h, H_REQ_LO, H_REQ_HI);
    pix_x     = 10'h3FF;
    pix_y     = 10'h3FF;
    if (pix_req) begin
      pix_x = cnt_h - H_REQ_LO;
      pix_y = cnt_v - VS_L;
    end
    rgb = rgb_valid ? pix_data : 16'h0000;
  end

  // End of frame is not needed downstream; keep the flag visibly consumed.
  logic unused_ok;
  assign unused_ok = v_tc;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: full horizontal timing with a shortened frame height
// so several complete frames fit in a short run.
module tb_vga_ctrl;

  localparam int H_SYNC = 96, H_BACK = 40, H_LEFT = 8, H_VALID = 640;
  localparam int H_RIGHT = 8, H_FRONT = 8, H_TOTAL = 800;
  localparam int V_SYNC = 2, V_BACK = 3, V_TOP = 1, V_VALID = 4;
  localparam int V_BOTTOM = 1, V_FRONT = 1, V_TOTAL = 12;
  localparam int HS = H_SYNC + H_BACK + H_LEFT;   // 144
  localparam int VS = V_SYNC + V_BACK + V_TOP;    // 6
  localparam int RUN_CYCLES = 30000;

  logic        vga_clk;
  logic        sys_rst_n;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;

  vga_ctrl #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_LEFT(H_LEFT), .H_VALID(H_VALID),
    .H_RIGHT(H_RIGHT), .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOP(V_TOP), .V_VALID(V_VALID),
    .V_BOTTOM(V_BOTTOM), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL)
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb)
  );

  // Clock and reset
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Scoreboard state
  logic [37:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  // Reference position and event trackers
  int h = 0, v = 0, frames = 0, cyc = 0, rel_cyc = 0;
  logic prev_hs = 1'b0, prev_vs = 1'b0;
  int hs_hi = 0, vs_hi = 0, h_last = 0, v_last = 0;
  bit h_seen = 0, v_seen = 0, h_align_pend = 0, v_align_pend = 0;
  bit did_mid = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", tag, obs, exp, h, v, $time);
    end
  endtask

  // Expected {hsync, vsync, pix_x, pix_y, rgb} for a position and input pixel.
  function automatic logic [37:0] model(input int hh, input int vv, input logic [15:0] pd);
    logic hs, vs, row, act, req;
    logic [9:0] px, py;
    hs  = hh < H_SYNC;
    vs  = vv < V_SYNC;
    row = (vv >= VS) && (vv < VS + V_VALID);
    act = row && (hh >= HS) && (hh < HS + H_VALID);
    req = row && (hh >= HS - 1) && (hh < HS + H_VALID - 1);
    px  = req ? 10'(hh - (HS - 1)) : 10'h3FF;
    py  = req ? 10'(vv - VS) : 10'h3FF;
    return {hs, vs, px, py, (act ? pd : 16'h0000)};
  endfunction

  task automatic advance();
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v++;
      if (v == V_TOTAL) begin
        v = 0;
        frames++;
      end
    end
  endtask

  task automatic reset_trackers();
    prev_hs = 1'b0; prev_vs = 1'b0;
    hs_hi = 0; vs_hi = 0;
    h_seen = 0; v_seen = 0;
  endtask

  task automatic check_reset_outputs(input string phase);
    check_eq({phase, "_hsync"}, 32'(hsync), 32'd1);
    check_eq({phase, "_vsync"}, 32'(vsync), 32'd1);
    check_eq({phase, "_pix_x"}, 32'(pix_x), 32'h3FF);
    check_eq({phase, "_pix_y"}, 32'(pix_y), 32'h3FF);
    check_eq({phase, "_rgb"},   32'(rgb),   32'h0000);
  endtask

  // One pixel clock: optional edge, drive pix_data, push expectation, compare.
  task automatic step_cycle(input bit do_edge);
    logic [15:0] pd;
    logic [37:0] e;
    if (do_edge) begin
      @(posedge vga_clk);
      cyc++;
      advance();
    end
    #2;
    if (frames == 0) begin
      if (h >= 300 && h < 400)      pd = 16'h07E0;
      else if (h >= 400 && h < 500) pd = 16'h001F;
      else                          pd = 16'hF800;
    end else begin
      pd = 16'($urandom_range(0, 16'hFFFF));
    end
    pix_data = pd;
    exp_q.push_back(model(h, v, pd));
    #1;
    e = exp_q.pop_front();
    check_eq("hsync", 32'(hsync), 32'(e[37]));
    check_eq("vsync", 32'(vsync), 32'(e[36]));
    check_eq("pix_x", 32'(pix_x), 32'(e[35:26]));
    check_eq("pix_y", 32'(pix_y), 32'(e[25:16]));
    check_eq("rgb",   32'(rgb),   32'(e[15:0]));

    // Request-window landmarks
    if (v == VS && h == HS - 1)                  check_eq("px_first", 32'(pix_x), 32'd0);
    if (v == VS && h == HS + H_VALID - 2)        check_eq("px_last",  32'(pix_x), 32'(H_VALID - 1));
    if (v == VS && h == HS + H_VALID - 1)        check_eq("px_after", 32'(pix_x), 32'h3FF);
    if (v == VS + V_VALID - 1 && h == HS)        check_eq("py_last",  32'(pix_y), 32'(V_VALID - 1));
    if (v == VS + V_VALID && h == HS)            check_eq("py_after", 32'(pix_y), 32'h3FF);

    // hsync pulse width, period and post-reset alignment
    if (hsync && !prev_hs) begin
      if (h_align_pend) begin
        check_eq("h_align", 32'(cyc - rel_cyc), 32'd0);
        h_align_pend = 0;
      end
      if (h_seen) check_eq("h_period", 32'(cyc - h_last), 32'(H_TOTAL));
      h_seen = 1;
      h_last = cyc;
    end
    if (hsync) hs_hi++;
    if (!hsync && prev_hs) begin
      check_eq("h_width", 32'(hs_hi), 32'(H_SYNC));
      hs_hi = 0;
    end
    prev_hs = hsync;

    // vsync pulse width, period and post-reset alignment
    if (vsync && !prev_vs) begin
      if (v_align_pend) begin
        check_eq("v_align", 32'(cyc - rel_cyc), 32'd0);
        v_align_pend = 0;
      end
      if (v_seen) check_eq("v_period", 32'(cyc - v_last), 32'(H_TOTAL * V_TOTAL));
      v_seen = 1;
      v_last = cyc;
    end
    if (vsync) vs_hi++;
    if (!vsync && prev_vs) begin
      check_eq("v_width", 32'(vs_hi), 32'(H_TOTAL * V_SYNC));
      vs_hi = 0;
    end
    prev_vs = vsync;
  endtask

  // Release reset on a falling edge and restart the reference at 0,0.
  task automatic release_reset();
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    h = 0;
    v = 0;
    rel_cyc = cyc;
    reset_trackers();
    h_align_pend = 1;
    v_align_pend = 1;
    step_cycle(1'b0);
  endtask

  // Abort the frame mid-line; outputs must drop without a clock edge.
  task automatic mid_frame_reset();
    pix_data = 16'hF800;
    #1;
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_async");
    repeat (3) @(posedge vga_clk);
    #2;
    check_reset_outputs("mid_held");
    release_reset();
  endtask

  // Main sequence
  initial begin
    sys_rst_n = 1'b0;
    pix_data  = 16'hFFFF;
    #100;
    check_reset_outputs("reset");
    release_reset();
    while (cyc < RUN_CYCLES) begin
      step_cycle(1'b1);
      if (!did_mid && frames == 1 && v == VS + 2 && h == 400) begin
        did_mid = 1;
        mid_frame_reset();
      end
    end
    if (!did_mid) check_eq("mid_reset_reached", 32'd0, 32'd1);
    if (exp_q.size() != 0) check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
